// File: rtl/c_drain_io_l3_out_serialize_c_m_axi_fifo.sv
// c_drain_io_l3_out_serialize_c_m_axi_fifo
// First-word-fall-through FIFO buffering serialized C words ahead of the
// m_axi write channel. Storage is a shift-register array (DEPTH-1 words)
// read at address occupancy-1, followed by a registered output stage.
// Optional feature macro: C_DRAIN_FIFO_ERR_FLAG_EN adds the sticky
// fifo_err[1:0] port (bit0 overflow, bit1 underflow).
module c_drain_io_l3_out_serialize_c_m_axi_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 63
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    output logic                  if_full_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   num_data_valid
`ifdef C_DRAIN_FIFO_ERR_FLAG_EN
    ,
    output logic [1:0]            fifo_err
`endif
);

    logic push;
    logic pop;
    logic dout_valid;

    assign if_empty_n = dout_valid;
    assign pop        = clk_en & if_read & dout_valid;

    generate
        if (DEPTH == 1) begin : g_reg_only
            // Single-entry FIFO: the output register is the only storage, so a
            // read in the same cycle frees room for the write (combinational path).
            assign if_full_n      = ~dout_valid | if_read;
            assign push           = clk_en & if_write & if_full_n;
            assign num_data_valid = {{ADDR_WIDTH{1'b0}}, dout_valid};

            // Output register loads straight from if_din.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    dout_valid <= 1'b0;
                    if_dout    <= '0;
                end else if (push) begin
                    dout_valid <= 1'b1;
                    if_dout    <= if_din;
                end else if (pop) begin
                    dout_valid <= 1'b0;
                end
            end
        end else begin : g_array
            localparam int unsigned         ARR_DEPTH = DEPTH - 1;
            localparam logic [ADDR_WIDTH:0] CNT_MAX   = (ADDR_WIDTH+1)'(DEPTH - 1);
            localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

            logic [DATA_WIDTH-1:0] mem [ARR_DEPTH];
            logic [ADDR_WIDTH:0]   arr_cnt;
            logic [ADDR_WIDTH-1:0] raddr;
            logic                  load;

            assign if_full_n      = (arr_cnt != CNT_MAX);
            assign push           = clk_en & if_write & if_full_n;
            assign load           = clk_en & (arr_cnt != '0) & (~dout_valid | pop);
            // Oldest word sits at the deepest occupied slot.
            assign raddr          = ADDR_WIDTH'(arr_cnt - CNT_ONE);
            assign num_data_valid = arr_cnt + {{ADDR_WIDTH{1'b0}}, dout_valid};

            // Shift register storage: new word enters at slot 0, no reset needed.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[0] <= if_din;
                    for (int unsigned i = 1; i < ARR_DEPTH; i++) begin
                        mem[i] <= mem[i-1];
                    end
                end
            end

            // Array occupancy: +1 on push, -1 on load, unchanged when both.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    arr_cnt <= '0;
                end else begin
                    case ({push, load})
                        2'b10:   arr_cnt <= arr_cnt + CNT_ONE;
                        2'b01:   arr_cnt <= arr_cnt - CNT_ONE;
                        default: arr_cnt <= arr_cnt;
                    endcase
                end
            end

            // Output stage: load reads pre-shift contents, so a coincident push
            // does not disturb the word being moved out.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    dout_valid <= 1'b0;
                    if_dout    <= '0;
                end else if (load) begin
                    dout_valid <= 1'b1;
                    if_dout    <= mem[raddr];
                end else if (pop) begin
                    dout_valid <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef C_DRAIN_FIFO_ERR_FLAG_EN
    // Sticky overflow/underflow flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fifo_err <= 2'b00;
        end else begin
            if (clk_en & if_write & ~if_full_n) fifo_err[0] <= 1'b1;
            if (clk_en & if_read & ~if_empty_n) fifo_err[1] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_c_drain_io_l3_out_serialize_c_m_axi_fifo.sv
// Self-checking bench for c_drain_io_l3_out_serialize_c_m_axi_fifo.
// Reference model: a queue of held words plus a flag recording whether the
// last enabled edge accepted a write (a lone freshly written word is not yet
// visible at the output).
module tb_c_drain_io_l3_out_serialize_c_m_axi_fifo;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 63;

    logic          clk = 1'b0;
    logic          reset_n, clk_en, if_write, if_read;
    logic [DW-1:0] if_din, if_dout;
    logic          if_full_n, if_empty_n;
    logic [AW:0]   num_data_valid;
`ifdef C_DRAIN_FIFO_ERR_FLAG_EN
    logic [1:0]    fifo_err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    bit            m_last_push;
    logic [1:0]    m_err;

    always #5 clk = ~clk;

    c_drain_io_l3_out_serialize_c_m_axi_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clk_en(clk_en),
        .if_full_n(if_full_n),
        .if_write(if_write),
        .if_din(if_din),
        .if_empty_n(if_empty_n),
        .if_read(if_read),
        .if_dout(if_dout),
        .num_data_valid(num_data_valid)
`ifdef C_DRAIN_FIFO_ERR_FLAG_EN
        ,
        .fifo_err(fifo_err)
`endif
    );

    function automatic bit m_full_n();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit m_empty_n();
        if (mq.size() == 0) return 1'b0;
        if (mq.size() >= 2) return 1'b1;
        return !m_last_push;
    endfunction

    function automatic logic [AW:0] m_count();
        return (AW+1)'(mq.size());
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return 1 time unit later.
    task automatic step(input bit rst_n_i, input bit en, input bit wr,
                        input logic [DW-1:0] din, input bit rd);
        bit push, pop;
        reset_n  = rst_n_i;
        clk_en   = en;
        if_write = wr;
        if_din   = din;
        if_read  = rd;
        push = en && wr && m_full_n();
        pop  = en && rd && m_empty_n();
        @(posedge clk);
        if (!rst_n_i) begin
            mq.delete();
            m_last_push = 1'b0;
            m_err       = 2'b00;
        end else if (en) begin
            if (wr && !m_full_n())  m_err[0] = 1'b1;
            if (rd && !m_empty_n()) m_err[1] = 1'b1;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(din);
            m_last_push = push;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, $urandom, 1'b0);
        checks++;
        if (if_full_n !== 1'b1) begin failures++; $display("FAIL reset_full_n got=%b exp=1", if_full_n); end
        checks++;
        if (if_empty_n !== 1'b0) begin failures++; $display("FAIL reset_empty_n got=%b exp=0", if_empty_n); end
        checks++;
        if (num_data_valid !== '0) begin failures++; $display("FAIL reset_num got=%0d exp=0", num_data_valid); end
        checks++;
        if (if_dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", if_dout); end
    endtask

    task automatic test_latency();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0);
        checks++;
        if (num_data_valid !== 7'd1) begin failures++; $display("FAIL lat_num_n got=%0d exp=1", num_data_valid); end
        checks++;
        if (if_empty_n !== 1'b0) begin failures++; $display("FAIL lat_empty_n_n got=%b exp=0", if_empty_n); end
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (if_empty_n !== 1'b1) begin failures++; $display("FAIL lat_empty_n_n1 got=%b exp=1", if_empty_n); end
        checks++;
        if (if_dout !== 32'hA5A5A5A5) begin failures++; $display("FAIL lat_dout got=%h exp=a5a5a5a5", if_dout); end
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (num_data_valid !== 7'd0 || if_empty_n !== 1'b0) begin
            failures++; $display("FAIL lat_drain num=%0d empty_n=%b exp=0/0", num_data_valid, if_empty_n);
        end
    endtask

    task automatic test_fill();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, 1'b1, DW'(i), 1'b0);
            checks++;
            if (if_full_n !== m_full_n()) begin
                failures++; $display("FAIL fill_full_n i=%0d got=%b exp=%b", i, if_full_n, m_full_n());
            end
        end
        checks++;
        if (if_full_n !== 1'b0) begin failures++; $display("FAIL fill_full got=%b exp=0", if_full_n); end
        step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        checks++;
        if (num_data_valid !== 7'd63) begin failures++; $display("FAIL fill_overwrite_num got=%0d exp=63", num_data_valid); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (if_empty_n !== 1'b1 || if_dout !== DW'(i)) begin
                failures++; $display("FAIL fill_read i=%0d empty_n=%b dout=%h exp=1/%h", i, if_empty_n, if_dout, DW'(i));
            end
            step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        end
        checks++;
        if (if_empty_n !== 1'b0 || num_data_valid !== '0) begin
            failures++; $display("FAIL fill_empty empty_n=%b num=%0d exp=0/0", if_empty_n, num_data_valid);
        end
    endtask

    task automatic test_streaming();
        int reads = 0;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int c = 0; c < 1000; c++) begin
            if (if_empty_n === 1'b1) reads++;
            step(1'b1, 1'b1, 1'b1, DW'(c), 1'b1);
            checks++;
            if (if_empty_n !== m_empty_n() || num_data_valid !== m_count() ||
                (m_empty_n() && if_dout !== mq[0])) begin
                failures++;
                $display("FAIL stream c=%0d empty_n=%b num=%0d dout=%h exp=%b/%0d/%h", c, if_empty_n,
                         num_data_valid, if_dout, m_empty_n(), m_count(), m_empty_n() ? mq[0] : '0);
            end
            if (c >= 2) begin
                checks++;
                if (num_data_valid !== 7'd2) begin
                    failures++; $display("FAIL stream_steady_num c=%0d got=%0d exp=2", c, num_data_valid);
                end
            end
        end
        checks++;
        if (reads != 998) begin failures++; $display("FAIL stream_throughput got=%0d exp=998", reads); end
    endtask

    task automatic test_clk_en();
        logic [DW-1:0] prev_dout;
        logic [AW:0]   prev_num;
        bit en, wr, rd;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            prev_dout = if_dout;
            prev_num  = num_data_valid;
            en = ($urandom_range(0, 3) != 0);
            if (c < 1500) begin
                wr = ($urandom_range(0, 9) < 9);
                rd = ($urandom_range(0, 9) < 3);
            end else begin
                wr = ($urandom_range(0, 9) < 3);
                rd = ($urandom_range(0, 9) < 9);
            end
            step(1'b1, en, wr, $urandom, rd);
            checks++;
            if (if_full_n !== m_full_n() || if_empty_n !== m_empty_n() || num_data_valid !== m_count() ||
                (m_empty_n() && if_dout !== mq[0])) begin
                failures++;
                $display("FAIL clken c=%0d full_n=%b empty_n=%b num=%0d dout=%h exp=%b/%b/%0d/%h", c,
                         if_full_n, if_empty_n, num_data_valid, if_dout, m_full_n(), m_empty_n(),
                         m_count(), m_empty_n() ? mq[0] : '0);
            end
            if (!en) begin
                checks++;
                if (if_dout !== prev_dout || num_data_valid !== prev_num) begin
                    failures++; $display("FAIL clken_freeze c=%0d dout=%h num=%0d exp=%h/%0d", c,
                                         if_dout, num_data_valid, prev_dout, prev_num);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, $urandom, 1'b0);
        checks++;
        if (num_data_valid !== 7'd20) begin failures++; $display("FAIL mid_held got=%0d exp=20", num_data_valid); end
        step(1'b0, 1'b1, 1'b1, $urandom, 1'b1);
        checks++;
        if (num_data_valid !== '0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            failures++; $display("FAIL mid_reset num=%0d empty_n=%b full_n=%b exp=0/0/1",
                                 num_data_valid, if_empty_n, if_full_n);
        end
        step(1'b1, 1'b1, 1'b1, 32'h1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h2, 1'b0);
        checks++;
        if (if_empty_n !== 1'b1 || if_dout !== 32'h1) begin
            failures++; $display("FAIL mid_first empty_n=%b dout=%h exp=1/00000001", if_empty_n, if_dout);
        end
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (if_dout !== 32'h2) begin failures++; $display("FAIL mid_second dout=%h exp=00000002", if_dout); end
    endtask

`ifdef C_DRAIN_FIFO_ERR_FLAG_EN
    task automatic test_err_flags();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (fifo_err !== 2'b00) begin failures++; $display("FAIL err_reset got=%b exp=00", fifo_err); end
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b1, $urandom, 1'b0);
        step(1'b1, 1'b1, 1'b1, $urandom, 1'b0);
        checks++;
        if (fifo_err !== 2'b01 || fifo_err !== m_err) begin
            failures++; $display("FAIL err_overflow got=%b exp=01", fifo_err);
        end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (fifo_err !== 2'b10 || fifo_err !== m_err) begin
            failures++; $display("FAIL err_underflow got=%b exp=10", fifo_err);
        end
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        clk_en   = 1'b0;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        m_last_push = 1'b0;
        m_err       = 2'b00;
        test_reset();
        test_latency();
        test_fill();
        test_streaming();
        test_clk_en();
        test_reset_midstream();
`ifdef C_DRAIN_FIFO_ERR_FLAG_EN
        test_err_flags();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
